// File: rtl/coeff_block_writer.sv
// coeff_block_writer
//
// Accepts dequantized DCT coefficients one per handshake in zigzag order,
// reorders each 8x8 block into raster order inside a ping-pong pair of
// 64-word buffers, and drains every full buffer to the pre-IDCT SRAM
// region as 64 consecutive single-word writes. Blocks land in the layout
// the IDCT fetch reads back: all Y blocks, then U, then V.
//
// Ports
//   Clock            rising-edge clock
//   Reset            synchronous, active-high
//   Start            one-cycle pulse that begins a frame (ignored while Busy)
//   Coeff_data       signed coefficient, written to SRAM verbatim
//   Coeff_valid      Coeff_data is valid this cycle
//   Coeff_ready      a coefficient is accepted this cycle if Coeff_valid is high
//   SRAM_address     registered SRAM word address
//   SRAM_write_data  registered SRAM write data
//   SRAM_we_n        registered write enable, 0 = write
//   Busy             high from the cycle after Start until Done
//   Done             one-cycle pulse after the final write of the frame
module coeff_block_writer #(
  parameter logic [17:0] PREIDCT_BASE = 18'd76800,
  parameter int          Y_BLOCKS     = 1200,
  parameter int          UV_BLOCKS    = 600,
  parameter int          DATA_W       = 16
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic signed [DATA_W-1:0] Coeff_data,
  input  logic                     Coeff_valid,
  output logic                     Coeff_ready,
  output logic [17:0]              SRAM_address,
  output logic [DATA_W-1:0]        SRAM_write_data,
  output logic                     SRAM_we_n,
  output logic                     Busy,
  output logic                     Done
);

  localparam logic [17:0] U_BASE     = PREIDCT_BASE + 18'(Y_BLOCKS * 64);
  localparam logic [17:0] V_BASE     = U_BASE + 18'(UV_BLOCKS * 64);
  localparam logic [11:0] Y_END      = 12'(Y_BLOCKS);
  localparam logic [11:0] U_END      = 12'(Y_BLOCKS + UV_BLOCKS);
  localparam logic [11:0] TOTAL_BLKS = 12'(Y_BLOCKS + 2 * UV_BLOCKS);

  typedef enum logic [1:0] {D_IDLE, D_PRIME, D_WRITE, D_DONE} drain_t;

  drain_t             state_q, state_d;
  logic [5:0]         k_q, k_d;
  logic               wsel_q, wsel_d, rsel_q, rsel_d;
  logic [1:0]         full_q, full_d;
  logic [11:0]        blocks_in_q, blocks_in_d, blocks_out_q, blocks_out_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [5:0]         idx_q, idx_d;
  logic [5:0]         bx_q, bx_d;
  logic [17:0]        row_base_q, row_base_d, blk_base_q, blk_base_d;
  logic               we_n_q, we_n_d;
  logic [17:0]        addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [11:0]        blk_nxt;
  logic               accept, y_plane;

  // Two 64-word buffers addressed as {buffer select, raster index}.
  logic signed [DATA_W-1:0] buf_mem [0:127];

  // Zigzag position -> raster index (row*8 + col).
  function automatic logic [5:0] zz_raster(input logic [5:0] k);
    logic [5:0] r;
    case (k)
      6'd0:  r = 6'd0;   6'd1:  r = 6'd1;   6'd2:  r = 6'd8;   6'd3:  r = 6'd16;
      6'd4:  r = 6'd9;   6'd5:  r = 6'd2;   6'd6:  r = 6'd3;   6'd7:  r = 6'd10;
      6'd8:  r = 6'd17;  6'd9:  r = 6'd24;  6'd10: r = 6'd32;  6'd11: r = 6'd25;
      6'd12: r = 6'd18;  6'd13: r = 6'd11;  6'd14: r = 6'd4;   6'd15: r = 6'd5;
      6'd16: r = 6'd12;  6'd17: r = 6'd19;  6'd18: r = 6'd26;  6'd19: r = 6'd33;
      6'd20: r = 6'd40;  6'd21: r = 6'd48;  6'd22: r = 6'd41;  6'd23: r = 6'd34;
      6'd24: r = 6'd27;  6'd25: r = 6'd20;  6'd26: r = 6'd13;  6'd27: r = 6'd6;
      6'd28: r = 6'd7;   6'd29: r = 6'd14;  6'd30: r = 6'd21;  6'd31: r = 6'd28;
      6'd32: r = 6'd35;  6'd33: r = 6'd42;  6'd34: r = 6'd49;  6'd35: r = 6'd56;
      6'd36: r = 6'd57;  6'd37: r = 6'd50;  6'd38: r = 6'd43;  6'd39: r = 6'd36;
      6'd40: r = 6'd29;  6'd41: r = 6'd22;  6'd42: r = 6'd15;  6'd43: r = 6'd23;
      6'd44: r = 6'd30;  6'd45: r = 6'd37;  6'd46: r = 6'd44;  6'd47: r = 6'd51;
      6'd48: r = 6'd58;  6'd49: r = 6'd59;  6'd50: r = 6'd52;  6'd51: r = 6'd45;
      6'd52: r = 6'd38;  6'd53: r = 6'd31;  6'd54: r = 6'd39;  6'd55: r = 6'd46;
      6'd56: r = 6'd53;  6'd57: r = 6'd60;  6'd58: r = 6'd61;  6'd59: r = 6'd54;
      6'd60: r = 6'd47;  6'd61: r = 6'd55;  6'd62: r = 6'd62;
      default: r = 6'd63;
    endcase
    return r;
  endfunction

  // Row offset inside a block: row*320 for luma, row*160 for chroma, as shifts.
  function automatic logic [17:0] row_offset(input logic [2:0] row, input logic y_pl);
    logic [17:0] r;
    r = {15'd0, row};
    return y_pl ? ((r << 8) + (r << 6)) : ((r << 7) + (r << 5));
  endfunction

  assign Coeff_ready     = busy_q && !full_q[wsel_q] && (blocks_in_q < TOTAL_BLKS);
  assign accept          = Coeff_valid && Coeff_ready;
  assign y_plane         = blocks_out_q < Y_END;
  assign SRAM_address    = addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;
  assign Busy            = busy_q;
  assign Done            = done_q;

  always_ff @(posedge Clock) begin
    if (accept) buf_mem[{wsel_q, zz_raster(k_q)}] <= Coeff_data;
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    wsel_d       = wsel_q;
    rsel_d       = rsel_q;
    full_d       = full_q;
    blocks_in_d  = blocks_in_q;
    blocks_out_d = blocks_out_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    idx_d        = idx_q;
    bx_d         = bx_q;
    row_base_d   = row_base_q;
    blk_base_d   = blk_base_q;
    we_n_d       = 1'b1;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    blk_nxt      = blocks_out_q + 12'd1;

    // A new frame rewinds every counter; Start is only honoured when idle.
    if (Start && !busy_q) begin
      busy_d       = 1'b1;
      k_d          = 6'd0;
      wsel_d       = 1'b0;
      rsel_d       = 1'b0;
      full_d       = 2'b00;
      blocks_in_d  = 12'd0;
      blocks_out_d = 12'd0;
      bx_d         = 6'd0;
      row_base_d   = PREIDCT_BASE;
      blk_base_d   = PREIDCT_BASE;
      state_d      = D_IDLE;
    end

    if (accept) begin
      if (k_q == 6'd63) begin
        full_d[wsel_q] = 1'b1;
        wsel_d         = !wsel_q;
        k_d            = 6'd0;
        blocks_in_d    = blocks_in_q + 12'd1;
      end else begin
        k_d = k_q + 6'd1;
      end
    end

    case (state_q)
      D_IDLE: begin
        idx_d = 6'd0;
        if (full_q[rsel_q]) state_d = D_PRIME;
      end
      D_PRIME: begin
        idx_d   = 6'd1;
        state_d = D_WRITE;
      end
      D_WRITE: begin
        idx_d = idx_q + 6'd1;
        if (idx_q == 6'd63) begin
          // The set above targets wsel, which is never rsel while rsel is
          // full, so both bit updates survive in the same cycle.
          full_d[rsel_q] = 1'b0;
          rsel_d         = !rsel_q;
          blocks_out_d   = blk_nxt;
          if (blk_nxt == Y_END) begin
            bx_d       = 6'd0;
            row_base_d = U_BASE;
            blk_base_d = U_BASE;
          end else if (blk_nxt == U_END) begin
            bx_d       = 6'd0;
            row_base_d = V_BASE;
            blk_base_d = V_BASE;
          end else if (bx_q == (y_plane ? 6'd39 : 6'd19)) begin
            // Next block row: eight pixel rows further down the plane.
            bx_d       = 6'd0;
            row_base_d = row_base_q + (y_plane ? 18'd2560 : 18'd1280);
            blk_base_d = row_base_q + (y_plane ? 18'd2560 : 18'd1280);
          end else begin
            bx_d       = bx_q + 6'd1;
            blk_base_d = blk_base_q + 18'd8;
          end
          state_d = (blk_nxt == TOTAL_BLKS) ? D_DONE : D_IDLE;
        end
      end
      D_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = D_IDLE;
      end
      default: state_d = D_IDLE;
    endcase

    // Buffer read of index idx_q lands directly in the output register.
    if (state_q == D_PRIME || state_q == D_WRITE) begin
      we_n_d  = 1'b0;
      addr_d  = blk_base_q + row_offset(idx_q[5:3], y_plane) + {15'd0, idx_q[2:0]};
      wdata_d = buf_mem[{rsel_q, idx_q}];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= D_IDLE;
      k_q          <= 6'd0;
      wsel_q       <= 1'b0;
      rsel_q       <= 1'b0;
      full_q       <= 2'b00;
      blocks_in_q  <= 12'd0;
      blocks_out_q <= 12'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      idx_q        <= 6'd0;
      bx_q         <= 6'd0;
      row_base_q   <= PREIDCT_BASE;
      blk_base_q   <= PREIDCT_BASE;
      we_n_q       <= 1'b1;
      addr_q       <= 18'd0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      wsel_q       <= wsel_d;
      rsel_q       <= rsel_d;
      full_q       <= full_d;
      blocks_in_q  <= blocks_in_d;
      blocks_out_q <= blocks_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      idx_q        <= idx_d;
      bx_q         <= bx_d;
      row_base_q   <= row_base_d;
      blk_base_q   <= blk_base_d;
      we_n_q       <= we_n_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule
